plru_tree_table: RTL
====================

PLRU_TREE_TABLE -- requirements
Module: plru_tree_table

Interface
REQ-001 The block SHALL take parameter NUM_SETS, default 128: number of sets, power of two, 2..1024.
REQ-002 The block SHALL take parameter NUM_WAYS, default 4: associativity, power of two, 2..16.
REQ-003 The block SHALL derive the local constants IDX_W = log2(NUM_SETS), WAY_W = log2(NUM_WAYS) and NODES = NUM_WAYS-1.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rd_index  input  IDX_W  set whose victim is queried.
REQ-007 valid_mask  input  NUM_WAYS  per-way line-valid bits for set rd_index.
REQ-008 evict_way  output  WAY_W  victim way for rd_index.
REQ-009 evict_valid  output  1  evict_way usable; low while busy.
REQ-010 upd_en  input  1  record an access this cycle.
REQ-011 upd_index  input  IDX_W  set accessed.
REQ-012 upd_way  input  WAY_W  way accessed (hit or fill).
REQ-013 flush_req  input  1  single-cycle pulse requesting a full LRU-state clear.
REQ-014 busy  output  1  flush sweep in progress.
REQ-015 flush_done  output  1  single-cycle pulse when the sweep completes.

Function
REQ-016 Storage SHALL be NUM_SETS x NODES tree bits in heap order: root is node 0; node n has children 2n+1 (left) and 2n+2 (right); leaves map left to right to ways 0..NUM_WAYS-1.
REQ-017 Victim walk SHALL be combinational from the stored bits of rd_index: start at the root; bit 0 -> go left, bit 1 -> go right; the leaf reached is the tree victim.
REQ-018 If valid_mask has any 0 bit, evict_way SHALL be the lowest-numbered invalid way; otherwise it SHALL be the tree victim.
REQ-019 On a rising edge with upd_en=1 and busy=0, every node on the path to upd_way SHALL be written to point away from it (1 where the path goes left, 0 where it goes right); nodes off the path are unchanged.
REQ-020 evict_way SHALL reflect state before a same-cycle update (no bypass); the update is visible the next cycle.
REQ-021 The FSM SHALL have states IDLE and SWEEP.
REQ-022 IDLE -> SWEEP on flush_req=1; the sweep counter loads 0.
REQ-023 In SWEEP, one set per cycle SHALL be cleared to all-zero, with the counter running 0..NUM_SETS-1.
REQ-024 After clearing set NUM_SETS-1, the FSM SHALL return to IDLE and pulse flush_done for exactly one cycle.
REQ-025 busy SHALL be 1 exactly while in SWEEP, giving a total sweep of NUM_SETS cycles.
REQ-026 flush_req while busy SHALL be ignored.
REQ-027 upd_en while busy SHALL be dropped.
REQ-028 If flush_req and upd_en coincide in IDLE, the flush SHALL win and the update SHALL be dropped.
REQ-029 evict_valid SHALL equal !busy; evict_way while busy is don't-care.

Reset
REQ-030 Asserting reset SHALL immediately clear all tree bits to 0, force IDLE, and set busy=0, flush_done=0 and the counter to 0.
REQ-031 A reset during SWEEP SHALL abort the sweep with no flush_done pulse.
REQ-032 After reset with valid_mask all ones, evict_way SHALL be 0 for every set and evict_valid SHALL be 1.

Structure
REQ-033 Shared package plru_pkg SHALL hold default NUM_SETS/NUM_WAYS values, the FSM state encoding (IDLE=0, SWEEP=1) and log2 and node-index helper functions.
REQ-034 Victim selection (tree walk plus invalid-way priority) SHALL be a combinational sub-module plru_victim_sel, parameterised by NUM_WAYS.
REQ-035 Storage, update logic and the FSM SHALL reside in plru_tree_table.

Verification
REQ-036 Reset, NUM_WAYS=4, valid_mask=1111 -> evict_way=0 for sets 0, 63 and 127.
REQ-037 Update set 5 with way 0, then valid_mask=1111 and rd_index=5 -> evict_way=2; next update way 2 -> evict_way=1; next update way 1 -> evict_way=3.
REQ-038 Set 9 with valid_mask=1011 -> evict_way=2, regardless of tree state.
REQ-039 Dirty several sets, then pulse flush_req -> busy for 128 cycles, one flush_done pulse, every set evicts 0; upd_en issued mid-sweep has no effect.
REQ-040 Assert reset 40 cycles into a sweep -> busy=0 immediately, no flush_done pulse, all sets evict 0.
REQ-041 NUM_WAYS=8, NUM_SETS=16: access ways 0..7 in order on set 3 -> evict_way=0.

Source files
------------

// File: rtl/plru_pkg.sv
// plru_pkg: shared defaults, FSM encoding and tree-index helpers for the PLRU table
package plru_pkg;
  localparam int DEF_NUM_SETS = 128;
  localparam int DEF_NUM_WAYS = 4;
  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;
  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  function automatic int left_child(input int n);
    return 2 * n + 1;
  endfunction
  function automatic int right_child(input int n);
    return 2 * n + 2;
  endfunction
  // depth of heap node n (root is depth 0)
  function automatic int node_depth(input int n);
    return log2(n + 2) - 1;
  endfunction
  // left-to-right position of heap node n within its level
  function automatic int node_pos(input int n);
    return n + 1 - (1 << node_depth(n));
  endfunction
endpackage

// File: rtl/plru_victim_sel.sv
// plru_victim_sel: tree walk to the PLRU leaf, overridden by the lowest invalid way
module plru_victim_sel
  import plru_pkg::*;
#(
  parameter int NUM_WAYS = DEF_NUM_WAYS,
  localparam int WAY_W = log2(NUM_WAYS),
  localparam int NODES = NUM_WAYS - 1
) (
  input  logic [NODES-1:0]    tree,
  input  logic [NUM_WAYS-1:0] valid_mask,
  output logic [WAY_W-1:0]    victim
);
  logic [2*NUM_WAYS-1:0] ext;
  logic [WAY_W:0]        node;
  logic [WAY_W-1:0]      tree_way;
  logic [WAY_W-1:0]      inv_way;
  logic [WAY_W-1:0]      cnt;
  logic [NUM_WAYS-1:0]   vm;
  logic                  found;
  // padding lets the walk index leaves without a narrower index width
  assign ext = {{(NUM_WAYS + 1){1'b0}}, tree};
  // walk root to leaf, then let any invalid way take priority
  always_comb begin
    node = '0;
    for (int l = 0; l < WAY_W; l++)
      node = ext[node] ? (WAY_W+1)'(right_child(int'(node))) : (WAY_W+1)'(left_child(int'(node)));
    tree_way = WAY_W'(node + 1'b1);
    vm = valid_mask;
    cnt = '0;
    found = 1'b0;
    inv_way = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (!found && !vm[0]) begin
        found = 1'b1;
        inv_way = cnt;
      end
      vm = vm >> 1;
      cnt = cnt + 1'b1;
    end
    victim = found ? inv_way : tree_way;
  end
endmodule

// File: rtl/plru_tree_table.sv
// plru_tree_table: per-set tree-PLRU state with access update and a one-set-per-cycle flush sweep
module plru_tree_table
  import plru_pkg::*;
#(
  parameter int NUM_SETS = DEF_NUM_SETS,
  parameter int NUM_WAYS = DEF_NUM_WAYS,
  localparam int IDX_W = log2(NUM_SETS),
  localparam int WAY_W = log2(NUM_WAYS),
  localparam int NODES = NUM_WAYS - 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_W-1:0]    rd_index,
  input  logic [NUM_WAYS-1:0] valid_mask,
  output logic [WAY_W-1:0]    evict_way,
  output logic                evict_valid,
  input  logic                upd_en,
  input  logic [IDX_W-1:0]    upd_index,
  input  logic [WAY_W-1:0]    upd_way,
  input  logic                flush_req,
  output logic                busy,
  output logic                flush_done
);
  logic [NODES-1:0] tree_q [NUM_SETS];
  logic [NODES-1:0] upd_mask;
  logic [NODES-1:0] upd_bits;
  logic [IDX_W-1:0] cnt;
  state_t           state;
  // a node lies on the access path when its level-prefix matches the top bits of upd_way;
  // it is then pointed at the sibling half of the way just touched
  for (genvar n = 0; n < NODES; n++) begin : g_node
    localparam int D = node_depth(n);
    assign upd_mask[n] = (upd_way >> (WAY_W - D)) == WAY_W'(node_pos(n));
    assign upd_bits[n] = ~upd_way[WAY_W-1-D];
  end
  plru_victim_sel #(.NUM_WAYS(NUM_WAYS)) u_sel (
    .tree       (tree_q[rd_index]),
    .valid_mask (valid_mask),
    .victim     (evict_way)
  );
  assign evict_valid = !busy;
  // flush sequencer: IDLE waits for a request, SWEEP walks every set once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      busy <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      if (state == IDLE) begin
        if (flush_req) begin
          state <= SWEEP;
          busy <= 1'b1;
          cnt <= '0;
        end
      end else begin
        cnt <= cnt + 1'b1;
        if (cnt == IDX_W'(NUM_SETS - 1)) begin
          state <= IDLE;
          busy <= 1'b0;
          flush_done <= 1'b1;
        end
      end
    end
  end
  // tree storage: sweep clears, otherwise accepted accesses rewrite their path; a flush request wins over an access
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tree_q <= '{default: '0};
    else if (state == SWEEP)
      tree_q[cnt] <= '0;
    else if (upd_en && !flush_req)
      tree_q[upd_index] <= (tree_q[upd_index] & ~upd_mask) | (upd_bits & upd_mask);
  end
endmodule
